sha3_digest_serializer: RTL and testbench
=========================================

// Module: sha3_digest_serializer
// PURPOSE
//  Downstream of the 24-round unrolled sha3 pipeline. Captures each finished 5x5x64 state on the
//  pipeline's ogood strobe, keeps the first DIGEST_LANES lanes, and streams them out as 64-bit
//  words over a valid/ready handshake. The pipeline cannot stall, so a small state FIFO absorbs
//  back-to-back results. A sticky flag reports any loss.
// PARAMETERS
//  DIGEST_LANES  4  lanes emitted per state, 1..25 (4=SHA3-256, 8=SHA3-512, 25=full-state dump)
//  FIFO_DEPTH    4  number of whole states buffered, power of two, >=2
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       async active-low reset
//  isample     in   1       state valid; driven by the pipeline's ogood
//  isa..ise    in   5x64 ea planes y=0..4; isa[x] is lane (x,y=0)
//  odata       out  64      current lane word
//  ovalid      out  1       odata valid
//  iready      in   1       consumer accepts odata
//  olast       out  1       current word is the final lane of its state
//  olane       out  5       index (x+5y) of the current lane
//  ocount      out  $clog2(FIFO_DEPTH+1)  states held, including the one being emitted
//  ooverflow   out  1       sticky: a state was dropped
//  iclear_ovf  in   1       clears ooverflow
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty, lane counter 0, ooverflow 0. ovalid,
//    olast, olane, odata and ocount all read 0.
//  - Lane order: idx 0..DIGEST_LANES-1, with lane idx = plane[idx/5][idx%5].
//  - Capture: when isample=1, the lanes are written at the tail on that edge.
//  - Latency: isample at edge N, FIFO empty -> ovalid=1 with lane 0 after edge N. Lanes are not registered twice.
//  - ovalid = (ocount!=0). odata, olane and olast come from the head entry and the lane counter.
//    odata=0 whenever ovalid=0.
//  - Handshake: a transfer happens when ovalid&&iready. Then the lane counter increments. On
//    the last lane it wraps to 0 and the head entry pops.
//  - ovalid, once raised, stays high until the transfer completes. odata is stable while stalled.
//  - Full with isample=1 and no pop that cycle: the incoming state is dropped, ooverflow<=1,
//    and the FIFO contents are unchanged.
//  - Full with isample=1 and a last-lane pop the same cycle: the push is accepted and ocount
//    stays at FIFO_DEPTH. No overflow.
//  - Empty with isample=1: ocount goes 0->1. There is no bypass path.
//  - iclear_ovf and an overflow event in the same cycle: the set wins (ooverflow=1).
//  - Pointer and lane counters wrap modulo FIFO_DEPTH and DIGEST_LANES.
//  - ocount is never > FIFO_DEPTH.
//  - rst_n asserted mid-stream: a partially emitted state is discarded, with no olast for it.
// CONFIGURATION
//  SHA3_SERIALIZER_BYTESWAP_EN:
//    defined   -> odata = byte-reversed lane ({lane[7:0],...,lane[63:56]}), big-endian stream
//    undefined -> odata = lane as held in the state (little-endian Keccak lane order)
//  The byte-swap is purely combinational on the output. Latency and handshake are unchanged.
// STRUCTURE
//  - sha3_pkg: typedef lane_t (logic[63:0]), plane_t (lane_t[5]), localparam STATE_LANES=25,
//    and function lane_sel(idx) mapping idx -> (plane,x). This package is shared with sha3_round_function users.
//  - Sub-module sha3_state_fifo: storage of DIGEST_LANES lanes x FIFO_DEPTH entries, with
//    wr_ptr/rd_ptr/count and push/pop/full/empty. The serializer owns the lane counter, output muxing,
//    overflow flag and the optional swap.
// TESTING
//  1 Reset, then one isample with lane(x,y)=64'h0100_0000_0000_0000*y+x and iready=1.
//    -> 4 words on consecutive cycles: olane 0,1,2,3, with olast only on lane 3. ocount 1->0.
//  2 iready toggled 1,0,0,1,... during emission -> no lane skipped or repeated. odata and olane
//    are held while stalled.
//  3 iready=0, then 5 isamples with FIFO_DEPTH=4 -> ocount=4 and ooverflow=1. Releasing iready gives
//    exactly the first 4 states in order. iclear_ovf then gives ooverflow=0.
//  4 FIFO full, with an isample in the same cycle as the last-lane transfer -> ooverflow stays 0,
//    ocount stays 4, and the new state is emitted last.
//  5 DIGEST_LANES=25 -> olane 0..24, with lane 5 = isb[0] and lane 24 = ise[4].
//    With SHA3_SERIALIZER_BYTESWAP_EN, lane 64'h0011223344556677 gives 64'h7766554433221100.
//  6 rst_n pulsed low after lane 1 of a state -> ovalid=0 and ocount=0 at once. The next isample
//    restarts at olane 0.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared Keccak state types and the lane-index helper used by the sha3
// datapath and its output serializer.
package sha3_pkg;

  localparam int STATE_LANES = 25;

  typedef logic [63:0] lane_t;
  typedef lane_t [4:0] plane_t;

  // Position of a lane inside the 5x5 state: plane y, column x.
  typedef struct packed {
    logic [2:0] y;
    logic [2:0] x;
  } lane_pos_t;

  // Linear lane index (x + 5y) -> (plane, x).
  function automatic lane_pos_t lane_sel(input int unsigned idx);
    lane_pos_t p;
    p.y = 3'(idx / 5);
    p.x = 3'(idx % 5);
    return p;
  endfunction

endpackage

// File: rtl/sha3_state_fifo.sv
// Whole-state FIFO: each entry holds LANES 64-bit lanes. The caller guarantees
// no pop when empty and no push when full unless a pop happens that cycle.
module sha3_state_fifo
  import sha3_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [LANES-1:0][63:0] wr_data,
  output logic [LANES-1:0][63:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  localparam int PW = $clog2(DEPTH);

  logic [LANES-1:0][63:0] mem [DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;

  // Storage has no reset; readers gate the head with empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/sha3_digest_serializer.sv
// Captures finished sha3 states on isample and streams the first DIGEST_LANES
// lanes as 64-bit words over valid/ready. Optional big-endian output is
// selected by defining SHA3_SERIALIZER_BYTESWAP_EN.
module sha3_digest_serializer
  import sha3_pkg::*;
#(
  parameter int DIGEST_LANES = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             isample,
  input  logic [4:0][63:0]                 isa,
  input  logic [4:0][63:0]                 isb,
  input  logic [4:0][63:0]                 isc,
  input  logic [4:0][63:0]                 isd,
  input  logic [4:0][63:0]                 ise,
  output logic [63:0]                      odata,
  output logic                             ovalid,
  input  logic                             iready,
  output logic                             olast,
  output logic [4:0]                       olane,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  ocount,
  output logic                             ooverflow,
  input  logic                             iclear_ovf
);

  localparam int LW = (DIGEST_LANES > 1) ? $clog2(DIGEST_LANES) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  plane_t [4:0]                  planes;
  logic [DIGEST_LANES-1:0][63:0] wr_lanes, head;
  logic                          push, pop, full, empty, xfer, last_lane, drop;
  logic [CW-1:0]                 count;
  logic [LW-1:0]                 lane_cnt;
  lane_t                         lane_word;
  logic                          unused_planes;

  assign planes        = {ise, isd, isc, isb, isa};
  assign unused_planes = ^planes;

  // Only the digest lanes are stored; lane idx comes from plane idx/5, column idx%5.
  for (genvar i = 0; i < DIGEST_LANES; i++) begin : g_lane
    localparam lane_pos_t P = lane_sel(i);
    assign wr_lanes[i] = planes[P.y][P.x];
  end

  assign ovalid    = !empty;
  assign xfer      = ovalid && iready;
  assign last_lane = (lane_cnt == LW'(DIGEST_LANES - 1));
  assign pop       = xfer && last_lane;
  // A full FIFO still accepts a state when the head leaves the same cycle.
  assign push      = isample && (!full || pop);
  assign drop      = isample && full && !pop;

  sha3_state_fifo #(
    .LANES (DIGEST_LANES),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_lanes),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Lane counter walks the head entry and wraps on its last lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lane_cnt <= '0;
    else if (xfer) lane_cnt <= last_lane ? '0 : lane_cnt + 1'b1;
  end

  // Sticky loss flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ooverflow <= 1'b0;
    else if (drop)       ooverflow <= 1'b1;
    else if (iclear_ovf) ooverflow <= 1'b0;
  end

  // Output word straight from the head entry, zero while idle.
  always_comb begin
    lane_word = head[lane_cnt];
    odata     = '0;
    if (ovalid) begin
`ifdef SHA3_SERIALIZER_BYTESWAP_EN
      for (int b = 0; b < 8; b++) odata[8*b +: 8] = lane_word[8*(7-b) +: 8];
`else
      odata = lane_word;
`endif
    end
  end

  assign olast  = ovalid && last_lane;
  assign olane  = ovalid ? 5'(lane_cnt) : 5'd0;
  assign ocount = count;

endmodule

// File: tb/tb_sha3_digest_serializer.sv
// Bench for sha3_digest_serializer: a queue-of-states reference model checks a
// 4-lane instance cycle by cycle; a 25-lane instance covers the full-state dump.
module tb_sha3_digest_serializer;

  typedef logic [63:0] lane_t;
  typedef lane_t st_t [25];

  localparam int NL  = 4;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic isample = 1'b0, iready = 1'b0, iclear_ovf = 1'b0;
  logic isample25 = 1'b0, iready25 = 1'b0;
  logic [4:0][63:0] isa = '0, isb = '0, isc = '0, isd = '0, ise = '0;

  logic [63:0] odata, odata25;
  logic        ovalid, olast, ooverflow, ovalid25, olast25, ooverflow25;
  logic [4:0]  olane, olane25;
  logic [2:0]  ocount, ocount25;

  int nvec = 0;
  int nerr = 0;

  st_t mq[$];
  int  mlane = 0;
  bit  movf  = 1'b0;

  always #5 clk = ~clk;

  sha3_digest_serializer #(.DIGEST_LANES(NL), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .isample(isample),
    .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .odata(odata), .ovalid(ovalid), .iready(iready), .olast(olast), .olane(olane),
    .ocount(ocount), .ooverflow(ooverflow), .iclear_ovf(iclear_ovf)
  );

  sha3_digest_serializer #(.DIGEST_LANES(25), .FIFO_DEPTH(DEP)) dut25 (
    .clk(clk), .rst_n(rst_n), .isample(isample25),
    .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .odata(odata25), .ovalid(ovalid25), .iready(iready25), .olast(olast25), .olane(olane25),
    .ocount(ocount25), .ooverflow(ooverflow25), .iclear_ovf(iclear_ovf)
  );

  // ---------------- reference model ----------------
  function automatic lane_t lane_at(int idx);
    int y = idx / 5;
    int x = idx % 5;
    case (y)
      0: return isa[x];
      1: return isb[x];
      2: return isc[x];
      3: return isd[x];
      default: return ise[x];
    endcase
  endfunction

  function automatic st_t cur_state();
    st_t s;
    for (int i = 0; i < 25; i++) s[i] = lane_at(i);
    return s;
  endfunction

  function automatic lane_t swp(lane_t v);
`ifdef SHA3_SERIALIZER_BYTESWAP_EN
    lane_t r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = v[8*(7-b) +: 8];
    return r;
`else
    return v;
`endif
  endfunction

  // {ovalid, olast, olane, ocount, ooverflow, odata}
  function automatic logic [74:0] exp_t();
    if (mq.size() == 0) return {1'b0, 1'b0, 5'd0, 3'd0, movf, 64'd0};
    return {1'b1, (mlane == NL-1), 5'(mlane), 3'(mq.size()), movf, swp(mq[0][mlane])};
  endfunction

  function automatic logic [74:0] obs_t();
    return {ovalid, olast, olane, ocount, ooverflow, odata};
  endfunction

  // One clock; the model consumes the inputs as they stand at the edge.
  task automatic step();
    bit v, x, p, f;
    @(posedge clk);
    v = (mq.size() != 0);
    x = v && iready;
    p = x && (mlane == NL-1);
    f = (mq.size() == DEP);
    if (x) begin
      if (p) begin mq.delete(0); mlane = 0; end
      else mlane++;
    end
    if (isample && f && !p) movf = 1'b1;
    else begin
      if (isample) mq.push_back(cur_state());
      if (iclear_ovf) movf = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    mq.delete();
    mlane = 0;
    movf  = 1'b0;
  endtask

  task automatic rand_planes();
    for (int x = 0; x < 5; x++) begin
      isa[x] = {$urandom, $urandom}; isb[x] = {$urandom, $urandom};
      isc[x] = {$urandom, $urandom}; isd[x] = {$urandom, $urandom};
      ise[x] = {$urandom, $urandom};
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    nvec++;
    if (obs_t() !== 75'd0) begin
      nerr++; $display("FAIL reset_outputs got=%h want=0", obs_t());
    end
    nvec++;
    if ({ovalid25, olast25, olane25, ocount25, ooverflow25, odata25} !== 75'd0) begin
      nerr++; $display("FAIL reset_outputs25 got=%h want=0",
                       {ovalid25, olast25, olane25, ocount25, ooverflow25, odata25});
    end
    rst_n = 1'b1;
    step();
    nvec++;
    if (obs_t() !== exp_t()) begin
      nerr++; $display("FAIL post_reset got=%h want=%h", obs_t(), exp_t());
    end
  endtask

  task automatic test_single();
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        lane_t v = 64'h0100_0000_0000_0000 * 64'(y) + 64'(x);
        case (y)
          0: isa[x] = v; 1: isb[x] = v; 2: isc[x] = v; 3: isd[x] = v; default: ise[x] = v;
        endcase
      end
    iready = 1'b1; isample = 1'b1;
    step();
    isample = 1'b0;
    for (int i = 0; i < NL; i++) begin
      nvec++;
      if (obs_t() !== exp_t() || olane !== 5'(i) || olast !== (i == NL-1) || odata !== swp(64'(i))) begin
        nerr++; $display("FAIL single_lane%0d got=%h want=%h", i, obs_t(), exp_t());
      end
      step();
    end
    nvec++;
    if (ovalid !== 1'b0 || ocount !== 3'd0) begin
      nerr++; $display("FAIL single_drain ovalid=%b ocount=%0d want 0/0", ovalid, ocount);
    end
  endtask

  task automatic test_stall();
    logic [7:0] pat = 8'b1001_1001;
    logic [63:0] pd;
    logic [4:0]  pl;
    bit          stalled;
    int          k = 0;
    rand_planes();
    isample = 1'b1; iready = 1'b0;
    step();
    isample = 1'b0;
    while (mq.size() != 0 && k < 40) begin
      nvec++;
      if (obs_t() !== exp_t()) begin
        nerr++; $display("FAIL stall_cyc%0d got=%h want=%h", k, obs_t(), exp_t());
      end
      iready = pat[k % 8];
      pd = odata; pl = olane; stalled = ovalid && !iready;
      step();
      if (stalled) begin
        nvec++;
        if (odata !== pd || olane !== pl || ovalid !== 1'b1) begin
          nerr++; $display("FAIL stall_hold got=%h/%0d want=%h/%0d", odata, olane, pd, pl);
        end
      end
      k++;
    end
    nvec++;
    if (mq.size() != 0 || ovalid !== 1'b0) begin
      nerr++; $display("FAIL stall_timeout ovalid=%b want 0", ovalid);
    end
  endtask

  task automatic test_overflow();
    int k;
    iready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      rand_planes(); isample = 1'b1; step();
    end
    isample = 1'b0;
    nvec++;
    if (ocount !== 3'd4 || ooverflow !== 1'b1 || obs_t() !== exp_t()) begin
      nerr++; $display("FAIL ovf_full ocount=%0d ovf=%b want 4/1", ocount, ooverflow);
    end
    iready = 1'b1; k = 0;
    while (mq.size() != 0 && k < 40) begin
      nvec++;
      if (obs_t() !== exp_t()) begin
        nerr++; $display("FAIL ovf_drain%0d got=%h want=%h", k, obs_t(), exp_t());
      end
      step(); k++;
    end
    iclear_ovf = 1'b1; step(); iclear_ovf = 1'b0;
    nvec++;
    if (ooverflow !== 1'b0 || ovalid !== 1'b0) begin
      nerr++; $display("FAIL ovf_clear ovf=%b ovalid=%b want 0/0", ooverflow, ovalid);
    end
    // drop and clear in the same cycle: the set wins
    iready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      rand_planes(); isample = 1'b1; step();
    end
    iclear_ovf = 1'b1; rand_planes();
    step();
    isample = 1'b0; iclear_ovf = 1'b0;
    nvec++;
    if (ooverflow !== 1'b1 || ocount !== 3'd4) begin
      nerr++; $display("FAIL ovf_set_wins ovf=%b ocount=%0d want 1/4", ooverflow, ocount);
    end
    iclear_ovf = 1'b1; iready = 1'b1; k = 0;
    while (mq.size() != 0 && k < 40) begin
      step(); iclear_ovf = 1'b0; k++;
      nvec++;
      if (obs_t() !== exp_t()) begin
        nerr++; $display("FAIL ovf_drain2_%0d got=%h want=%h", k, obs_t(), exp_t());
      end
    end
  endtask

  task automatic test_full_pop();
    lane_t first_new;
    int    k = 0;
    iready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      rand_planes(); isample = 1'b1; step();
    end
    isample = 1'b0; iready = 1'b1;
    while (mlane != NL-1) step();
    rand_planes(); first_new = isa[0]; isample = 1'b1;
    step();
    isample = 1'b0;
    nvec++;
    if (ocount !== 3'd4 || ooverflow !== 1'b0 || obs_t() !== exp_t()) begin
      nerr++; $display("FAIL full_pop ocount=%0d ovf=%b want 4/0", ocount, ooverflow);
    end
    while (mq.size() != 0 && k < 40) begin
      if (mq.size() == 1 && mlane == 0) begin
        nvec++;
        if (odata !== swp(first_new)) begin
          nerr++; $display("FAIL full_pop_last got=%h want=%h", odata, swp(first_new));
        end
      end
      nvec++;
      if (obs_t() !== exp_t()) begin
        nerr++; $display("FAIL full_pop_drain%0d got=%h want=%h", k, obs_t(), exp_t());
      end
      step(); k++;
    end
  endtask

  task automatic test_wide();
    lane_t bs_exp;
    rand_planes();
    isample25 = 1'b1; iready25 = 1'b1;
    @(posedge clk); @(negedge clk);
    isample25 = 1'b0;
    for (int i = 0; i < 25; i++) begin
      nvec++;
      if (ovalid25 !== 1'b1 || olane25 !== 5'(i) || olast25 !== (i == 24) || odata25 !== swp(lane_at(i))) begin
        nerr++; $display("FAIL wide_lane%0d got=%h/%0d/%b want=%h/%0d/%b",
                         i, odata25, olane25, olast25, swp(lane_at(i)), i, (i == 24));
      end
      @(posedge clk); @(negedge clk);
    end
    nvec++;
    if (ovalid25 !== 1'b0 || ocount25 !== 3'd0) begin
      nerr++; $display("FAIL wide_drain ovalid=%b ocount=%0d want 0/0", ovalid25, ocount25);
    end
    isa[0] = 64'h0011223344556677;
`ifdef SHA3_SERIALIZER_BYTESWAP_EN
    bs_exp = 64'h7766554433221100;
`else
    bs_exp = 64'h0011223344556677;
`endif
    isample25 = 1'b1; iready25 = 1'b0;
    @(posedge clk); @(negedge clk);
    isample25 = 1'b0;
    nvec++;
    if (odata25 !== bs_exp || olane25 !== 5'd0) begin
      nerr++; $display("FAIL wide_swap got=%h want=%h", odata25, bs_exp);
    end
    iready25 = 1'b1;
    for (int i = 0; i < 25; i++) begin @(posedge clk); @(negedge clk); end
    iready25 = 1'b0;
  endtask

  task automatic test_midreset();
    rand_planes();
    isample = 1'b1; iready = 1'b1;
    step();
    isample = 1'b0;
    step(); step();
    nvec++;
    if (obs_t() !== exp_t() || olane !== 5'd2) begin
      nerr++; $display("FAIL midrst_pre got=%h want=%h", obs_t(), exp_t());
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if (ovalid !== 1'b0 || ocount !== 3'd0 || olast !== 1'b0) begin
      nerr++; $display("FAIL midrst_async ovalid=%b ocount=%0d want 0/0", ovalid, ocount);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rand_planes(); isample = 1'b1;
    step();
    isample = 1'b0;
    for (int i = 0; i < NL; i++) begin
      nvec++;
      if (obs_t() !== exp_t() || olane !== 5'(i)) begin
        nerr++; $display("FAIL midrst_restart%0d got=%h want=%h", i, obs_t(), exp_t());
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_planes();
      isample    = ($urandom_range(2) == 0);
      iready     = ($urandom_range(1) == 0);
      iclear_ovf = ($urandom_range(15) == 0);
      step();
      nvec++;
      if (obs_t() !== exp_t()) begin
        nerr++; $display("FAIL random_cyc%0d got=%h want=%h", c, obs_t(), exp_t());
      end
    end
    isample = 1'b0; iclear_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_full_pop();
    test_wide();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
